// File: rtl/booth_seq_mult_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : booth_seq_mult_if                                               |
// | Purpose  : Handshake and operand bundle for the sequential Booth MUL unit. |
// |            master = requester (drives start/mode/operands),               |
// |            slave  = multiplier (drives busy/done/product).                |
// | Signals  : start, signed_mode, multiplicand[WIDTH], multiplier[WIDTH],     |
// |            busy, done, product[2*WIDTH]                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface booth_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output signed_mode,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  signed_mode,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : booth_seq_mult                                                  |
// | Purpose  : Self-sequencing radix-2 Booth multiplier with start/busy/done   |
// |            handshake and per-operation signed/unsigned mode.              |
// | Ports    : clk   - rising-edge clock                                      |
// |            reset - synchronous, active-high reset (aborts any operation)  |
// |            bus   - booth_seq_mult_if.slave: start, signed_mode,           |
// |                    multiplicand, multiplier in; busy, done, product out   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  wire              clk,
    input  wire              reset,
    booth_seq_mult_if.slave  bus
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 2);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [WIDTH:0]       r_m_ext;
    logic [WIDTH+1:0]     r_a;
    logic [WIDTH:0]       r_q_ext;
    logic                 r_qm1;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    // Operands extended by one bit so unsigned values stay positive in the
    // two's-complement Booth datapath.
    logic [WIDTH:0]       w_m_load;
    logic [WIDTH:0]       w_q_load;
    logic [WIDTH+1:0]     w_m_wide;
    logic [WIDTH+1:0]     w_a_sum;
    logic [2*WIDTH+3:0]   w_shift;
    logic [WIDTH+1:0]     w_a_nxt;
    logic [WIDTH:0]       w_q_nxt;
    logic                 w_qm1_nxt;

    assign w_m_load = {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
    assign w_q_load = {bus.signed_mode & bus.multiplier[WIDTH-1],   bus.multiplier};
    assign w_m_wide = {r_m_ext[WIDTH], r_m_ext};

    always_comb begin
        w_a_sum = r_a;
        case ({r_q_ext[0], r_qm1})
            2'b01:   w_a_sum = r_a + w_m_wide;
            2'b10:   w_a_sum = r_a - w_m_wide;
            default: w_a_sum = r_a;
        endcase
    end

    // Arithmetic right shift of {A, Q_ext, Qm1} applied to the post-add A.
    assign w_shift   = {w_a_sum[WIDTH+1], w_a_sum, r_q_ext};
    assign w_a_nxt   = w_shift[2*WIDTH+3:WIDTH+2];
    assign w_q_nxt   = w_shift[WIDTH+1:1];
    assign w_qm1_nxt = w_shift[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_m_ext   <= '0;
            r_a       <= '0;
            r_q_ext   <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_m_ext <= w_m_load;
                        r_q_ext <= w_q_load;
                        r_a     <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    r_a     <= w_a_nxt;
                    r_q_ext <= w_q_nxt;
                    r_qm1   <= w_qm1_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_CNT) begin
                        // Product is taken from the final step's result so it
                        // lands in the same edge that enters DONE.
                        r_product <= w_shift[2*WIDTH:1];
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (bus.start) begin
                        r_m_ext <= w_m_load;
                        r_q_ext <= w_q_load;
                        r_a     <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_CALC;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule
`default_nettype wire
